// File: rtl/execute_unit.sv
// Execute stage of the z8 core: single-cycle ALU ops plus a 16-iteration
// shift-add multiply, with a one-cycle registered writeback to the register file.
module execute_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  opcode,
    input  logic [15:0] operand_a,
    input  logic [15:0] operand_b,
    input  logic [1:0]  dest_addr,
    output logic        busy,
    output logic        wb_enable,
    output logic [1:0]  wb_addr,
    output logic [15:0] wb_data,
    output logic        flag_zero,
    output logic        flag_carry
);

    localparam int DATA_W = 16;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_SHL = 3'd5;
    localparam logic [2:0] OP_MUL = 3'd6;
    localparam logic [2:0] OP_MOV = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        WB   = 2'd2
    } state_t;

    state_t state, state_next;

    logic [1:0]          dest_p0;
    logic [2*DATA_W-1:0] mcand_p0;
    logic [2*DATA_W-1:0] acc_p0;
    logic [DATA_W-1:0]   mplier_p0;
    logic [3:0]          iter_p0;

    logic [DATA_W:0]     alu_res;
    logic [2*DATA_W-1:0] acc_sum;

    // Returns {carry, result} for every opcode except MUL.
    function automatic logic [DATA_W:0] alu(input logic [2:0] op,
                                            input logic [DATA_W-1:0] a,
                                            input logic [DATA_W-1:0] b);
        logic [2*DATA_W-1:0] sh;
        sh = {{DATA_W{1'b0}}, a} << b[3:0];
        case (op)
            OP_ADD:  alu = {1'b0, a} + {1'b0, b};
            OP_SUB:  alu = {(a < b), a - b};
            OP_AND:  alu = {1'b0, a & b};
            OP_OR:   alu = {1'b0, a | b};
            OP_XOR:  alu = {1'b0, a ^ b};
            OP_SHL:  alu = {sh[DATA_W], sh[DATA_W-1:0]};
            OP_MOV:  alu = {1'b0, b};
            default: alu = '0;
        endcase
    endfunction

    assign alu_res = alu(opcode, operand_a, operand_b);
    assign acc_sum = acc_p0 + (mplier_p0[0] ? mcand_p0 : '0);
    assign busy    = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = (opcode == OP_MUL) ? MUL : WB;
            MUL:     if (iter_p0 == 4'd15) state_next = WB;
            WB:      state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Writeback registers load on the edge entering WB so the strobe cycle
    // already presents address, data and flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            wb_enable  <= 1'b0;
            wb_addr    <= '0;
            wb_data    <= '0;
            flag_zero  <= 1'b0;
            flag_carry <= 1'b0;
            dest_p0    <= '0;
            mcand_p0   <= '0;
            acc_p0     <= '0;
            mplier_p0  <= '0;
            iter_p0    <= '0;
        end else begin
            wb_enable <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        dest_p0   <= dest_addr;
                        mcand_p0  <= {{DATA_W{1'b0}}, operand_a};
                        mplier_p0 <= operand_b;
                        acc_p0    <= '0;
                        iter_p0   <= '0;
                        if (opcode != OP_MUL) begin
                            wb_enable  <= 1'b1;
                            wb_addr    <= dest_addr;
                            wb_data    <= alu_res[DATA_W-1:0];
                            flag_zero  <= (alu_res[DATA_W-1:0] == '0);
                            flag_carry <= alu_res[DATA_W];
                        end
                    end
                end
                MUL: begin
                    acc_p0    <= acc_sum;
                    mcand_p0  <= mcand_p0 << 1;
                    mplier_p0 <= mplier_p0 >> 1;
                    iter_p0   <= iter_p0 + 4'd1;
                    if (iter_p0 == 4'd15) begin
                        wb_enable  <= 1'b1;
                        wb_addr    <= dest_p0;
                        wb_data    <= acc_sum[DATA_W-1:0];
                        flag_zero  <= (acc_sum[DATA_W-1:0] == '0);
                        flag_carry <= |acc_sum[2*DATA_W-1:DATA_W];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
